// File: rtl/systolic_pkg.sv
// Shared types, sizing helper and default parameters for the systolic multiplier.
package systolic_pkg;

  localparam int N_DEF  = 4;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    OUT
  } state_e;

  // Ceiling log2. Used only when working out widths at elaboration time.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/systolic_matmul_n_if.sv
// Operand stream, result stream and status bundle of the systolic multiplier.
interface systolic_matmul_n_if
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
);
  localparam int AW = 2 * DW + clog2(N);

  logic            start_i;
  logic            signed_i;
  logic            valid_i;
  logic            ready_o;
  logic [N*DW-1:0] a_col_i;
  logic [N*DW-1:0] b_row_i;
  logic            res_valid_o;
  logic            res_ready_i;
  logic [N*AW-1:0] res_row_o;
  logic            res_last_o;
  logic            busy_o;
  logic            done_o;

  // Requester side: supplies operands and consumes result rows.
  modport master (
    output start_i, signed_i, valid_i, a_col_i, b_row_i, res_ready_i,
    input  ready_o, res_valid_o, res_row_o, res_last_o, busy_o, done_o
  );

  // Multiplier side.
  modport slave (
    input  start_i, signed_i, valid_i, a_col_i, b_row_i, res_ready_i,
    output ready_o, res_valid_o, res_row_o, res_last_o, busy_o, done_o
  );

endinterface

// File: rtl/systolic_matmul_n_pe_mac.sv
// One processing element: forwards A right and B down, accumulates a*b.
module pe_mac #(
  parameter int DW = 32,
  parameter int AW = 66
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          signed_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] a_o,
  output logic [DW-1:0] b_o,
  output logic [AW-1:0] acc_o
);

  logic        [2*DW-1:0] prod_u;
  logic signed [2*DW-1:0] prod_s;
  logic        [AW-1:0]   prod_ext;

  // Both product flavours, extended to accumulator width per the latched mode.
  always_comb begin
    prod_u   = a_i * b_i;
    prod_s   = $signed(a_i) * $signed(b_i);
    prod_ext = signed_i ? AW'(prod_s) : AW'(prod_u);
  end

  // Operand forwarding registers and the wrapping accumulator.
  // NOTE: sequential state uses <= so every PE samples its neighbour's old value on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_o   <= '0;
      b_o   <= '0;
      acc_o <= '0;
    end else begin
      a_o <= a_i;
      b_o <= b_i;
      if (clr_i) acc_o <= '0;
      else       acc_o <= acc_o + prod_ext;
    end
  end

endmodule

// File: rtl/systolic_matmul_n.sv
// Output-stationary N x N systolic matrix multiplier, C = A * B.
// Beat k carries column k of A and row k of B; C is read out one row per handshake.
module systolic_matmul_n
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
) (
  input logic                clk_i,
  input logic                rst_ni,
  systolic_matmul_n_if.slave bus
);

  localparam int AW  = 2 * DW + clog2(N);
  localparam int CW  = (clog2(N) > 0) ? clog2(N) : 1;
  localparam int DCW = clog2(2 * N);

  state_e         state_q, state_d;
  logic [CW-1:0]  beat_q;
  logic [CW-1:0]  row_q;
  logic [DCW-1:0] drain_q;
  logic           signed_q;
  logic           done_q;

  logic start_fire, beat_fire, last_beat, drain_end, row_fire, last_row;

  logic [DW-1:0] a_feed [N];
  logic [DW-1:0] b_feed [N];
  logic [DW-1:0] a_h    [N][N+1];
  logic [DW-1:0] b_v    [N+1][N];
  logic [AW-1:0] acc    [N][N];

  assign start_fire = (state_q == IDLE) && bus.start_i;
  assign beat_fire  = (state_q == LOAD) && bus.valid_i;
  assign last_beat  = beat_fire && (beat_q == CW'(N - 1));
  assign drain_end  = (state_q == DRAIN) && (drain_q == DCW'(2 * N - 2));
  assign row_fire   = (state_q == OUT) && bus.res_ready_i;
  assign last_row   = row_fire && (row_q == CW'(N - 1));

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d is defaulted first so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_fire) state_d = LOAD;
      LOAD:    if (last_beat)  state_d = DRAIN;
      DRAIN:   if (drain_end)  state_d = OUT;
      OUT:     if (last_row)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Beat, drain and row counters, latched mode and the completion pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beat_q   <= '0;
      row_q    <= '0;
      drain_q  <= '0;
      signed_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= last_row;
      if (start_fire) begin
        signed_q <= bus.signed_i;
        beat_q   <= '0;
      end else if (beat_fire) begin
        beat_q <= beat_q + CW'(1);
      end
      if (state_q == DRAIN) drain_q <= drain_q + DCW'(1);
      else                  drain_q <= '0;
      if (drain_end)     row_q <= '0;
      else if (row_fire) row_q <= row_q + CW'(1);
    end
  end

  // Lane feeds: accepted beat data, otherwise zeros (bubbles and drain).
  always_comb begin
    for (int l = 0; l < N; l++) begin
      a_feed[l] = beat_fire ? bus.a_col_i[l*DW +: DW] : '0;
      b_feed[l] = beat_fire ? bus.b_row_i[l*DW +: DW] : '0;
    end
  end

  // Input skew: lane l is delayed l cycles so operands meet in the right PE.
  for (genvar l = 0; l < N; l++) begin : g_skew
    if (l == 0) begin : g_direct
      assign a_h[0][0] = a_feed[0];
      assign b_v[0][0] = b_feed[0];
    end else begin : g_delay
      logic [DW-1:0] a_sr [l];
      logic [DW-1:0] b_sr [l];

      // Shift-register delay line for this lane.
      // NOTE: the skew stages are reset so an aborted run cannot leak operands into the next one.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int d = 0; d < l; d++) begin
            a_sr[d] <= '0;
            b_sr[d] <= '0;
          end
        end else begin
          a_sr[0] <= a_feed[l];
          b_sr[0] <= b_feed[l];
          for (int d = 1; d < l; d++) begin
            a_sr[d] <= a_sr[d-1];
            b_sr[d] <= b_sr[d-1];
          end
        end
      end

      assign a_h[l][0] = a_sr[l-1];
      assign b_v[0][l] = b_sr[l-1];
    end

    // Operands leaving the right and bottom edges go nowhere.
    logic [DW-1:0] edge_unused;
    assign edge_unused = a_h[l][N] ^ b_v[N][l];
  end

  // PE array.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      pe_mac #(
        .DW (DW),
        .AW (AW)
      ) u_pe (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (start_fire),
        .signed_i (signed_q),
        .a_i      (a_h[i][j]),
        .b_i      (b_v[i][j]),
        .a_o      (a_h[i][j+1]),
        .b_o      (b_v[i+1][j]),
        .acc_o    (acc[i][j])
      );
    end
  end

  // Result row mux, shown only while presenting results.
  always_comb begin
    bus.res_row_o = '0;
    if (state_q == OUT) begin
      for (int j = 0; j < N; j++) bus.res_row_o[j*AW +: AW] = acc[row_q][j];
    end
  end

  assign bus.ready_o     = (state_q == LOAD);
  assign bus.res_valid_o = (state_q == OUT);
  assign bus.res_last_o  = (state_q == OUT) && (row_q == CW'(N - 1));
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.done_o      = done_q;

endmodule

// File: tb/tb_systolic_matmul_n.sv
// Directed and randomised checks of systolic_matmul_n at N=4, DW=8.
module tb_systolic_matmul_n;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 18;

  logic clk_i;
  logic rst_ni;

  systolic_matmul_n_if #(.N(N), .DW(DW)) bus ();

  systolic_matmul_n #(.N(N), .DW(DW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fails  = 0;

  logic [DW-1:0]   a_m [N][N];
  logic [DW-1:0]   b_m [N][N];
  logic [N*AW-1:0] sb [$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Golden model: pushes the N expected result rows onto the scoreboard.
  task automatic push_expected(input logic sgn);
    logic [N*AW-1:0] row;
    longint          s;
    for (int r = 0; r < N; r++) begin
      row = '0;
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) begin
          if (sgn) s += longint'($signed(a_m[r][k])) * longint'($signed(b_m[k][j]));
          else     s += longint'(a_m[r][k]) * longint'(b_m[k][j]);
        end
        row[j*AW +: AW] = s[AW-1:0];
      end
      sb.push_back(row);
    end
  endtask

  // One complete multiply; optional bubbles, output stalls, stray start pulses,
  // or a reset two cycles into DRAIN.
  task automatic run_mm(input logic sgn, input bit bubbles, input bit stalls,
                        input bit poke, input bit abort);
    int              cyc;
    int              rows;
    int              guard;
    bit              rr;
    bit              stalled_prev;
    logic [N*AW-1:0] prev_row;

    push_expected(sgn);
    bus.start_i  = 1'b1;
    bus.signed_i = sgn;
    tick();
    bus.start_i  = poke;
    bus.signed_i = ~sgn;
    check("busy_after_start", bus.busy_o, 1'b1);
    check("ready_in_load", bus.ready_o, 1'b1);

    for (int k = 0; k < N; k++) begin
      if (bubbles) begin
        while ($urandom_range(1, 0) == 1) begin
          bus.valid_i = 1'b0;
          tick();
        end
      end
      bus.valid_i = 1'b1;
      for (int i = 0; i < N; i++) begin
        bus.a_col_i[i*DW +: DW] = a_m[i][k];
        bus.b_row_i[i*DW +: DW] = b_m[k][i];
      end
      check("ready_on_beat", bus.ready_o, 1'b1);
      tick();
      bus.valid_i = 1'b0;
      bus.a_col_i = '0;
      bus.b_row_i = '0;
    end
    bus.start_i = 1'b0;

    if (abort) begin
      tick();
      tick();
      rst_ni = 1'b0;
      #1;
      check("rst_busy", bus.busy_o, 1'b0);
      check("rst_res_valid", bus.res_valid_o, 1'b0);
      check("rst_ready", bus.ready_o, 1'b0);
      check("rst_res_row", bus.res_row_o, '0);
      #3;
      rst_ni = 1'b1;
      sb.delete();
      return;
    end

    cyc = 0;
    while (!bus.res_valid_o && cyc < 20) begin
      tick();
      cyc++;
    end
    check("drain_latency", cyc, 2 * N - 1);
    if (!bus.res_valid_o) begin
      sb.delete();
      return;
    end

    rows = 0;
    guard = 0;
    stalled_prev = 1'b0;
    while (rows < N && guard < 200) begin
      rr = stalls ? bit'($urandom_range(1, 0)) : 1'b1;
      if (stalled_prev) check("row_stable", bus.res_row_o, prev_row);
      check("res_valid", bus.res_valid_o, 1'b1);
      check("res_last", bus.res_last_o, (rows == N - 1));
      check("res_row", bus.res_row_o, sb[0]);
      bus.res_ready_i = rr;
      bus.start_i     = poke && !rr;
      prev_row        = bus.res_row_o;
      stalled_prev    = !rr;
      tick();
      bus.start_i = 1'b0;
      if (rr) begin
        void'(sb.pop_front());
        rows++;
      end
      guard++;
    end
    bus.res_ready_i = 1'b0;
    check("rows_read", rows, N);
    check("done_pulse", bus.done_o, 1'b1);
    check("idle_busy", bus.busy_o, 1'b0);
    check("idle_res_valid", bus.res_valid_o, 1'b0);
    tick();
    check("done_one_cycle", bus.done_o, 1'b0);
    sb.delete();
  endtask

  initial begin
    bus.start_i     = 1'b0;
    bus.signed_i    = 1'b0;
    bus.valid_i     = 1'b0;
    bus.a_col_i     = '0;
    bus.b_row_i     = '0;
    bus.res_ready_i = 1'b0;
    rst_ni          = 1'b0;
    #2;
    check("reset_busy", bus.busy_o, 1'b0);
    check("reset_ready", bus.ready_o, 1'b0);
    check("reset_res_valid", bus.res_valid_o, 1'b0);
    check("reset_done", bus.done_o, 1'b0);
    check("reset_res_row", bus.res_row_o, '0);
    #10;
    rst_ni = 1'b1;

    // Identity times B: C[r][j] = 4r+j.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_m[i][k] = (i == k) ? 8'd1 : 8'd0;
        b_m[i][k] = 8'(4 * i + k);
      end
    run_mm(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // All 255 unsigned: 4*255*255 = 260100 everywhere.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_m[i][k] = 8'hFF;
        b_m[i][k] = 8'hFF;
      end
    run_mm(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // All 0x80: 65536 in both signed and unsigned mode.
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_m[i][k] = 8'h80;
        b_m[i][k] = 8'h80;
      end
    run_mm(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_mm(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random operands with bubbles and output stalls, both modes.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++)
        for (int k = 0; k < N; k++) begin
          a_m[i][k] = 8'($urandom);
          b_m[i][k] = 8'($urandom);
        end
      run_mm(1'(t % 2), 1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Stray start pulses during LOAD and OUT must be ignored.
    run_mm(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Reset mid-DRAIN, then a full run starting on the first edge after release.
    run_mm(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        a_m[i][k] = 8'($urandom);
        b_m[i][k] = 8'($urandom);
      end
    run_mm(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/systolic_matmul_n.md
SYSTOLIC_MATMUL_N -- requirements
Module: systolic_matmul_n

Interface
REQ-001 The block SHALL take parameter N, default 4, meaning the array dimension (N x N PEs, N x N operands).
REQ-002 The block SHALL take parameter DW, default 32, meaning the operand element width.
REQ-003 The block SHALL use localparam AW = 2*DW + clog2(N) as the accumulator and result element width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk_i and rst_ni.
REQ-005 clk_i  input  1  rising-edge clock for all state.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 start_i  input  1  request a new multiply; accepted only in IDLE.
REQ-008 signed_i  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start_i.
REQ-009 valid_i  input  1  operand beat valid.
REQ-010 ready_o  output  1  operand beat accepted when valid_i & ready_o.
REQ-011 a_col_i  input  N*DW  beat k: element i = A[i][k].
REQ-012 b_row_i  input  N*DW  beat k: element j = B[k][j].
REQ-013 res_valid_o  output  1  result row valid.
REQ-014 res_ready_i  input  1  result row consumed when res_valid_o & res_ready_i.
REQ-015 res_row_o  output  N*AW  element j = C[r][j] for current row r.
REQ-016 res_last_o  output  1  high with res_valid_o on row N-1.
REQ-017 busy_o  output  1  high in any state other than IDLE.
REQ-018 done_o  output  1  one-cycle pulse after the final result-row handshake.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, DRAIN, OUT.
REQ-020 IDLE->LOAD on start_i; the same edge SHALL clear all accumulators, latch signed_i, zero the beat counter.
REQ-021 ready_o SHALL be 1 only in LOAD; start_i outside IDLE SHALL be ignored.
REQ-022 Each accepted beat SHALL increment the beat counter; LOAD->DRAIN on acceptance of beat N-1.
REQ-023 Cycles in LOAD with valid_i low SHALL inject zeros into all lanes (bubble) without advancing the counter; results SHALL be unaffected.
REQ-024 Input skew: A lane i SHALL be delayed i cycles, B lane j SHALL be delayed j cycles, before entering row i / column j.
REQ-025 PE(i,j) SHALL forward A right and B down with one register each and accumulate acc += a*b every cycle.
REQ-026 Products SHALL be 2*DW wide, sign- or zero-extended per latched mode to AW; accumulation wraps modulo 2^AW (cannot overflow for N products).
REQ-027 DRAIN SHALL inject zeros and last exactly 2N-1 cycles, then go to OUT with row index r = 0.
REQ-028 In OUT res_valid_o SHALL be 1 and res_row_o SHALL show row r; r advances on handshake; res_row_o stable while res_ready_i low.
REQ-029 Handshake on row N-1 SHALL move OUT->IDLE and assert done_o the next cycle for one cycle.
REQ-030 Accumulators SHALL hold C until the next accepted start_i.

Reset
REQ-031 rst_ni low SHALL asynchronously force IDLE, counters 0, accumulators and pipeline registers 0, all outputs 0, at any state including mid-LOAD/DRAIN/OUT.
REQ-032 After reset release the block SHALL accept start_i on the first rising edge.

Structure
REQ-033 Package systolic_pkg SHALL hold the FSM state enum, the clog2 function and default N/DW constants.
REQ-034 One sub-module pe_mac (params DW, AW; ports clk_i, rst_ni, clr_i, signed_i, a_i, b_i, a_o, b_o, acc_o) SHALL be instantiated N*N times via generate.

Verification (N=4, DW=8)
REQ-035 A = identity, B[k][j] = 4k+j -> rows read C[r][j] = 4r+j, res_last_o on row 3, done_o one pulse.
REQ-036 Unsigned, all operands 255 -> every C element 260100.
REQ-037 signed_i=1, all operands 0x80 -> every C element 65536; signed_i=0 same data -> 65536 (128*128*4).
REQ-038 Random A,B with valid_i low 50% of LOAD cycles and res_ready_i low 50% of OUT cycles -> C matches golden model, res_row_o stable during stalls.
REQ-039 start_i pulsed during LOAD and OUT -> ignored, result unchanged; rst_ni low mid-DRAIN -> busy_o=0, res_valid_o=0 immediately, next full run correct.
